irq_controller: RTL

Memory-mapped interrupt controller between the accelerator status/done logic and the MIPS core's single interrupt line. Edge-detects up to four interrupt sources into pending bits, applies a software mask, and selects one source. It then runs an assert / acknowledge / end-of-interrupt handshake with the CPU and presents the selected source number as a vector. A guaranteed low gap on `cpu_irq` separates consecutive interrupts.

---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_prio_sel.sv | 31 +++
 rtl/irq_controller.sv | 119 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and register addresses for the interrupt controller
package irq_pkg;

  localparam int NUM_SRC_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_GAP     = 2'd3
  } irq_state_t;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SWSET   = 2'd3;

endpackage

// File: rtl/irq_prio_sel.sv
// rtl/irq_prio_sel.sv - picks the first eligible source searching upward from start (wrapping)
module irq_prio_sel
  import irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int VEC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [VEC_W-1:0]   start,
  output logic               valid,
  output logic [VEC_W-1:0]   winner
);

  logic [VEC_W-1:0] idx;

  // Descending scan so the smallest offset from start is the last one written.
  // Index wrap relies on NUM_SRC being a power of two.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = start + VEC_W'(i);
      if (eligible[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-detected, masked interrupt controller with ack/EOI handshake
// Define IRQ_RR_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int VEC_W      = $clog2(NUM_SRC),
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               we,
  input  logic               re,
  input  logic [1:0]         addr,
  input  logic [31:0]        wd,
  output logic [31:0]        rd,
  output logic               cpu_irq,
  output logic [VEC_W-1:0]   irq_vec,
  input  logic               cpu_ack,
  input  logic               eoi
);

  localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES);

  irq_state_t         state, state_nxt;
  logic [NUM_SRC-1:0] src_q, pending, pending_nxt, mask;
  logic [NUM_SRC-1:0] set_bits, clr_bits;
  logic               in_service;
  logic [1:0]         gap_cnt;
  logic               latch_vec, ack_take, eoi_take;
  logic               sel_valid;
  logic [VEC_W-1:0]   sel_idx, start;
  logic [31:0]        rd_val;
  logic               unused_wd;

  assign unused_wd = ^wd[31:NUM_SRC];

`ifdef IRQ_RR_EN
  logic [VEC_W-1:0] last_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           last_ack <= VEC_W'(NUM_SRC - 1);
    else if (ack_take) last_ack <= irq_vec;
  end

  assign start = last_ack + VEC_W'(1);
`else
  assign start = '0;
`endif

  irq_prio_sel #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) u_sel (
    .eligible (pending & mask),
    .start    (start),
    .valid    (sel_valid),
    .winner   (sel_idx)
  );

  always_comb begin
    state_nxt = state;
    latch_vec = 1'b0;
    ack_take  = 1'b0;
    eoi_take  = 1'b0;
    case (state)
      ST_IDLE:    if (sel_valid) begin state_nxt = ST_ASSERT;  latch_vec = 1'b1; end
      ST_ASSERT:  if (cpu_ack)   begin state_nxt = ST_SERVICE; ack_take  = 1'b1; end
      ST_SERVICE: if (eoi)       begin state_nxt = ST_GAP;     eoi_take  = 1'b1; end
      ST_GAP:     if (gap_cnt == 2'd0) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign cpu_irq = (state == ST_ASSERT);

  // Sets are applied after clears so a new edge beats a W1C or ack clear.
  always_comb begin
    set_bits = src_in & ~src_q;
    clr_bits = '0;
    if (we && addr == ADDR_PENDING) clr_bits = wd[NUM_SRC-1:0];
    if (we && addr == ADDR_SWSET)   set_bits = set_bits | wd[NUM_SRC-1:0];
    if (ack_take)                   clr_bits[irq_vec] = 1'b1;
    pending_nxt = (pending & ~clr_bits) | set_bits;
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_PENDING: rd_val = 32'(pending);
      ADDR_MASK:    rd_val = 32'(mask);
      ADDR_STATUS:  rd_val = 32'({in_service, irq_vec, state});
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      src_q      <= '0;
      pending    <= '0;
      mask       <= '0;
      in_service <= 1'b0;
      gap_cnt    <= 2'd0;
      irq_vec    <= '0;
      rd         <= '0;
    end else begin
      state   <= state_nxt;
      src_q   <= src_in;
      pending <= pending_nxt;
      if (we && addr == ADDR_MASK) mask <= wd[NUM_SRC-1:0];
      if (latch_vec) irq_vec <= sel_idx;
      if (ack_take)      in_service <= 1'b1;
      else if (eoi_take) in_service <= 1'b0;
      if (eoi_take)                                 gap_cnt <= GAP_LOAD;
      else if (state == ST_GAP && gap_cnt != 2'd0)  gap_cnt <= gap_cnt - 2'd1;
      if (re) rd <= rd_val;
    end
  end

endmodule
